// File: rtl/runway_pkg.sv
// runway_pkg: wind codes and pattern helpers shared by the runway light sequencer.
package runway_pkg;
  typedef enum logic [1:0] {
    WIND_CALM = 2'b00,
    WIND_UP   = 2'b01,
    WIND_DOWN = 2'b10,
    WIND_BAD  = 2'b11
  } wind_e;

  function automatic logic [31:0] calm_pattern(input logic [4:0] i, input logic [5:0] n);
    return (32'd1 << i) | (32'd1 << (n - 6'd1 - {1'b0, i}));
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction
endpackage

// File: rtl/runway_light_seq_tick_prescaler.sv
// tick_prescaler: free-running 0..TICK_DIV-1 counter, tick high on the terminal count.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(TICK_DIV - 1);
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/runway_light_seq.sv
// runway_light_seq: calm converging pair / directional sweep lamp sequencer.
// RUNWAY_LIGHT_SEQ_ERR_EN makes code 11 hold the pattern and raise err.
module runway_light_seq
  import runway_pkg::*;
#(
  parameter int N_LIGHTS = 8,
  parameter int TICK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          wind,
  output logic [N_LIGHTS-1:0] lights,
  output logic                step,
  output logic                err
);
  localparam int CI_MAX = (N_LIGHTS + 1) / 2 - 1;
  localparam int CIW = $clog2(CI_MAX + 1);
  localparam logic [N_LIGHTS-1:0] CALM0 = N_LIGHTS'(calm_pattern(5'd0, 6'(N_LIGHTS)));
  logic tick, legal, onehot;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [CIW-1:0] ci_q, ci_d, ci_n;
  logic calm_q, calm_d, step_q, err_q, err_d;
  wind_e mode;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (.clk(clk), .reset(reset), .tick(tick));
`ifdef RUNWAY_LIGHT_SEQ_ERR_EN
  assign legal = wind != WIND_BAD;
`else
  assign legal = 1'b1;
`endif
  assign mode = wind_e'(wind);
  assign onehot = is_onehot(32'(lights_q));
  always_comb begin
    ci_n = calm_q ? (ci_q == CIW'(CI_MAX) ? '0 : ci_q + 1'b1) : '0;
    lights_d = lights_q;
    ci_d = ci_q;
    calm_d = calm_q;
    err_d = tick ? !legal : err_q;
    if (tick && legal) begin
      if (mode == WIND_UP) begin
        lights_d = onehot ? {lights_q[N_LIGHTS-2:0], lights_q[N_LIGHTS-1]} : N_LIGHTS'(1);
        calm_d = 1'b0;
      end else if (mode == WIND_DOWN) begin
        lights_d = onehot ? {lights_q[0], lights_q[N_LIGHTS-1:1]} : {1'b1, {(N_LIGHTS-1){1'b0}}};
        calm_d = 1'b0;
      end else begin
        ci_d = ci_n;
        lights_d = N_LIGHTS'(calm_pattern(5'(ci_n), 6'(N_LIGHTS)));
        calm_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lights_q <= CALM0;
      ci_q <= '0;
      calm_q <= 1'b1;
      step_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      lights_q <= lights_d;
      ci_q <= ci_d;
      calm_q <= calm_d;
      step_q <= tick;
      err_q <= err_d;
    end
  end
  assign lights = lights_q;
  assign step = step_q;
  assign err = err_q;
endmodule

// File: doc/runway_light_seq.md
# runway_light_seq

Parametrised runway landing-light sequencer driving `N_LIGHTS` lamps from a 2-bit wind-direction code. It steps once per prescaled tick, which makes the sequence visible on real lamps. The patterns are:

- calm: a converging pair of lights,
- wind: a single light sweeping in the indicated direction.

The block sits between the board switch synchroniser and the LED driver, and succeeds the fixed 3-lamp landing-light FSM.

## Interface

Parameters:
- `N_LIGHTS`, default 8: lamp count, legal range 3..32.
- `TICK_DIV`, default 4: clock cycles per pattern step, at least 1. A value of 1 steps every cycle.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `wind`  in  2  mode code:
  - 00 calm,
  - 01 sweep toward MSB,
  - 10 sweep toward LSB,
  - 11 illegal.
- `lights`  out  `N_LIGHTS`  registered lamp pattern.
- `step`  out  1  one-cycle pulse in the cycle `lights` takes a new value.
- `err`  out  1  registered; high while the last sampled code was 11 (macro-dependent).

## Operation

- State:
  - pattern register `lights`,
  - calm index `ci`, range 0..`CI_MAX`, where `CI_MAX` = ceil(`N_LIGHTS`/2)-1,
  - flag `calm_q`, meaning the last step was calm,
  - prescaler count.
- Calm pattern(i) = bit i | bit `N_LIGHTS`-1-i.
  - `N_LIGHTS`=8: i=0..3 gives 0x81, 0x42, 0x24, 0x18.
  - `N_LIGHTS`=3: 101, 010.
- `wind` is sampled only on a tick cycle (prescaler count = `TICK_DIV`-1). `wind` is ignored on other cycles.
- On a tick:
  - **00:** if `calm_q`, `ci` advances, and wraps from `CI_MAX` to 0. Otherwise `ci` is set to 0. Then `lights` = calm pattern(`ci`) and `calm_q` is set to 1.
  - **01:** if `lights` is one-hot, rotate left (MSB wraps to bit 0). Otherwise load bit 0. `calm_q` is cleared.
  - **10:** if `lights` is one-hot, rotate right (bit 0 wraps to MSB). Otherwise load MSB. `calm_q` is cleared.
  - **11:** handled per Configuration.
- The one-hot test is purely combinational on `lights`. The odd-N centre calm pattern is one-hot, so it rotates.
- `lights` is never all-zero outside the 11 case.

## Timing

- Reset values:
  - `lights` = calm pattern(0),
  - `ci` = 0,
  - `calm_q` = 1,
  - `step` = 0,
  - `err` = 0,
  - prescaler count = 0.
- Prescaler counts 0..`TICK_DIV`-1 and wraps.
- Latency:
  - The tick is the cycle in which the count equals `TICK_DIV`-1.
  - The pattern update is visible at the next edge. `step` is high in that cycle.
  - The first update appears `TICK_DIV` edges after reset deasserts.
- `wind` changing between ticks has no effect. Only the value present on the tick cycle matters.
- Reset asserted mid-sweep or mid-prescale:
  - all state returns to the reset values at the next edge,
  - no `step` pulse is issued during reset.
- `TICK_DIV`=1: the count is permanently 0, so every cycle is a tick and `step` is held high.

## Configuration

- `RUNWAY_LIGHT_SEQ_ERR_EN` defined: code 11 on a tick
  - holds `lights`, `ci` and `calm_q` unchanged,
  - sets `err`=1 and still pulses `step`.
  - `err` clears on the next tick with a legal code.
- Not defined:
  - code 11 is treated exactly as 00 (calm),
  - `err` is tied to 0.

## Structure

- Package `runway_pkg`:
  - `wind_e` enum: `WIND_CALM`=2'b00, `WIND_UP`=2'b01, `WIND_DOWN`=2'b10, `WIND_BAD`=2'b11,
  - function `calm_pattern(i, n)`,
  - function `is_onehot`.
- Sub-module `tick_prescaler`:
  - parameter `TICK_DIV`, ports `clk`, `reset`, `tick`,
  - instantiated once.
- The sequencer is a single always_ff for state and registered outputs, plus an always_comb next-state block.

## Test plan

1. **Reset, then calm, N=8, TICK_DIV=1.** Stimulus: reset high 2 cycles, then `wind`=00. Expect `lights` = 0x81 in reset, then 0x42, 0x24, 0x18, 0x81, ..., with `step` high every cycle.
2. **Sweep up from calm, N=8, TICK_DIV=1.** Stimulus: from 0x42, `wind`=01. Expect 0x01, 0x02, ..., 0x80, 0x01 (wrap). Switching to 00 mid-sweep gives 0x81 next.
3. **Sweep down, N=8, TICK_DIV=1.** Stimulus: from 0x81, `wind`=10. Expect 0x80, 0x40, ..., 0x01, 0x80. Switching to 01 from 0x10 gives 0x20.
4. **Legacy equivalence, N=3, TICK_DIV=1.** Expect:
   - 00: 101 ↔ 010,
   - 01 from 010: 100, 001, 010,
   - 10 from 101: 100, 010, 001.
5. **Prescale, N=8, TICK_DIV=4.**
   - `step` pulses every 4th cycle, and the first pulse comes 4 edges after reset release.
   - A `wind`=01 glitch lasting 1 non-tick cycle leaves the calm sequence unchanged.
   - Reset asserted at count 2 returns `lights` to 0x81 with no `step`.
6. **Illegal code, N=8, TICK_DIV=1, in 0x04 sweep.** Stimulus: `wind`=11 for 2 ticks, then 01.
   - With `RUNWAY_LIGHT_SEQ_ERR_EN`: `lights` holds 0x04 and `err`=1 for 2 ticks; then `lights` = 0x08 and `err`=0.
   - Without it: `lights` = 0x81, 0x42, then 0x01, with `err`=0 throughout.
